// File: rtl/pwm_duty_decoder.sv
// PWM input decoder: measures high time, period and 8-bit duty in prescaled ticks.
// Optional glitch filter on the synchronized input is enabled by PWM_DECODER_GLITCH_FILTER_EN.
module pwm_duty_decoder #(
   parameter int unsigned DIV_MAX = 3334,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             pwm_in,
   output logic [7:0]       duty,
   output logic [CNT_W-1:0] high_ticks,
   output logic [CNT_W-1:0] period_ticks,
   output logic             valid,
   output logic             static_flag,
   output logic             static_level
);

   localparam logic [11:0]      PRESC_LAST = 12'(DIV_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] DUTY_SAT   = CNT_W'(255);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             lvl;
   logic [11:0]      presc_q, presc_d;
   logic             tick;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d, idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0] high_inc, low_inc, idle_inc;
   logic [CNT_W:0]   period_sum;
   logic             rise, fall;
   logic [7:0]       duty_q, duty_d;
   logic [CNT_W-1:0] high_ticks_q, high_ticks_d, period_ticks_q, period_ticks_d;
   logic             valid_q, valid_d, static_flag_q, static_flag_d;
   logic             static_level_q, static_level_d;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
   // Filtered level follows s2 only after 3 consecutive clks of disagreement.
   logic       flt_q, flt_d;
   logic [1:0] flt_cnt_q, flt_cnt_d;

   always_comb begin
      flt_d     = flt_q;
      flt_cnt_d = 2'd0;
      if (s2_q != flt_q) begin
         if (flt_cnt_q == 2'd2) flt_d = s2_q;
         else flt_cnt_d = flt_cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_q     <= 1'b0;
         flt_cnt_q <= 2'd0;
      end else begin
         flt_q     <= flt_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   assign lvl = flt_q;
`else
   assign lvl = s2_q;
`endif

   assign rise = lvl & ~s3_q;
   assign fall = ~lvl & s3_q;

   assign tick    = ena & (presc_q == PRESC_LAST);
   assign presc_d = (!ena || tick) ? 12'd0 : presc_q + 12'd1;

   assign high_inc = (tick && state_q == StHigh && high_cnt_q != CNT_MAX) ? high_cnt_q + CNT_ONE
                                                                          : high_cnt_q;
   assign low_inc  = (tick && state_q == StLow && low_cnt_q != CNT_MAX) ? low_cnt_q + CNT_ONE
                                                                        : low_cnt_q;
   assign idle_inc = (tick && idle_cnt_q != CNT_MAX) ? idle_cnt_q + CNT_ONE : idle_cnt_q;

   // The tick of the closing edge belongs to the LOW phase being left.
   assign period_sum = {1'b0, high_cnt_q} + {1'b0, low_inc};

   always_comb begin
      state_d        = state_q;
      high_cnt_d     = high_inc;
      low_cnt_d      = low_inc;
      idle_cnt_d     = idle_inc;
      duty_d         = duty_q;
      high_ticks_d   = high_ticks_q;
      period_ticks_d = period_ticks_q;
      valid_d        = 1'b0;
      static_flag_d  = static_flag_q;
      static_level_d = static_level_q;
      if (!ena) begin
         state_d    = StIdle;
         high_cnt_d = '0;
         low_cnt_d  = '0;
         idle_cnt_d = '0;
      end else if (rise || fall) begin
         idle_cnt_d = '0;
         case (state_q)
            StIdle: begin
               if (rise) begin
                  state_d    = StHigh;
                  high_cnt_d = '0;
                  low_cnt_d  = '0;
               end
            end
            StHigh: begin
               if (fall) begin
                  state_d   = StLow;
                  low_cnt_d = '0;
               end
            end
            StLow: begin
               if (rise) begin
                  state_d        = StHigh;
                  high_ticks_d   = high_cnt_q;
                  period_ticks_d = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];
                  duty_d         = (high_cnt_q > DUTY_SAT) ? 8'hFF : high_cnt_q[7:0];
                  static_flag_d  = 1'b0;
                  valid_d        = 1'b1;
                  high_cnt_d     = '0;
                  low_cnt_d      = '0;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (!static_flag_q && idle_cnt_q >= TIMEOUT_C) begin
         state_d        = StIdle;
         static_flag_d  = 1'b1;
         static_level_d = s2_q;
         duty_d         = {8{s2_q}};
         high_ticks_d   = '0;
         period_ticks_d = '0;
         valid_d        = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q           <= 1'b0;
         s2_q           <= 1'b0;
         s3_q           <= 1'b0;
         presc_q        <= 12'd0;
         state_q        <= StIdle;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         idle_cnt_q     <= '0;
         duty_q         <= 8'd0;
         high_ticks_q   <= '0;
         period_ticks_q <= '0;
         valid_q        <= 1'b0;
         static_flag_q  <= 1'b0;
         static_level_q <= 1'b0;
      end else begin
         s1_q           <= pwm_in;
         s2_q           <= s1_q;
         s3_q           <= lvl;
         presc_q        <= presc_d;
         state_q        <= state_d;
         high_cnt_q     <= high_cnt_d;
         low_cnt_q      <= low_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         duty_q         <= duty_d;
         high_ticks_q   <= high_ticks_d;
         period_ticks_q <= period_ticks_d;
         valid_q        <= valid_d;
         static_flag_q  <= static_flag_d;
         static_level_q <= static_level_d;
      end
   end

   assign duty         = duty_q;
   assign high_ticks   = high_ticks_q;
   assign period_ticks = period_ticks_q;
   assign valid        = valid_q;
   assign static_flag  = static_flag_q;
   assign static_level = static_level_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: directed and randomized PWM waveforms checked every clk
// against a tick-timestamp model of the decoder.
module tb_pwm_duty_decoder;

   localparam int unsigned DIV = 4;
   localparam int unsigned TMO = 400;
   localparam int unsigned CW  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b1;
   logic          pwm_in = 1'b0;
   logic [7:0]    duty;
   logic [CW-1:0] high_ticks, period_ticks;
   logic          valid, static_flag, static_level;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   pwm_duty_decoder #(.DIV_MAX(DIV), .CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in), .duty(duty),
      .high_ticks(high_ticks), .period_ticks(period_ticks), .valid(valid),
      .static_flag(static_flag), .static_level(static_level)
   );

   always #5 clk = ~clk;

   // Model: input delay line, run length since enable, cumulative tick count and
   // tick timestamps of the last rise, fall and any edge.
   logic m_d1, m_d2, m_h1, m_h2, m_flt, m_lprev;
   int   m_run, m_cum, m_trise, m_tfall, m_tedge, m_phase;  // phase 0 none, 1 high, 2 low
   int   e_duty, e_high, e_period, e_valid, e_static, e_slevel;

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_clear();
      m_d1 = 0; m_d2 = 0; m_h1 = 0; m_h2 = 0; m_flt = 0; m_lprev = 0;
      m_run = 0; m_cum = 0; m_trise = 0; m_tfall = 0; m_tedge = 0; m_phase = 0;
      e_duty = 0; e_high = 0; e_period = 0; e_valid = 0; e_static = 0; e_slevel = 0;
   endtask

   task automatic model_edge();
      logic lv, ev, rv, s2pre;
      int   cum_before, hi, lo;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      lv = m_flt;
`else
      lv = m_d2;
`endif
      ev    = (lv != m_lprev);
      rv    = ev & lv;
      s2pre = m_d2;
      if (m_d2 != m_flt && m_h1 != m_flt && m_h2 != m_flt) m_flt = m_d2;
      m_lprev = lv;
      m_h2 = m_h1; m_h1 = m_d2; m_d2 = m_d1; m_d1 = pwm_in;
      e_valid = 0;
      if (!ena) begin
         m_run = 0; m_cum = 0; m_tedge = 0; m_phase = 0;
      end else begin
         cum_before = m_cum;
         m_run++;
         if (m_run % DIV == 0) m_cum++;
         if (ev) begin
            if (m_phase == 0 && rv) begin
               m_phase = 1; m_trise = m_cum;
            end else if (m_phase == 1 && !rv) begin
               m_phase = 2; m_tfall = m_cum;
            end else if (m_phase == 2 && rv) begin
               hi = m_tfall - m_trise;
               lo = m_cum - m_tfall;
               e_high = sat(hi); e_period = sat(hi + lo);
               e_duty = (hi > 255) ? 255 : hi;
               e_static = 0; e_valid = 1;
               m_phase = 1; m_trise = m_cum;
            end
            m_tedge = m_cum;
         end else if (e_static == 0 && cum_before - m_tedge >= int'(TMO)) begin
            m_phase = 0; e_static = 1; e_slevel = int'(s2pre);
            e_duty = s2pre ? 255 : 0; e_high = 0; e_period = 0; e_valid = 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_all();
      chk("valid", 32'(valid), 32'(e_valid));
      chk("duty", 32'(duty), 32'(e_duty));
      chk("high_ticks", 32'(high_ticks), 32'(e_high));
      chk("period_ticks", 32'(period_ticks), 32'(e_period));
      chk("static_flag", 32'(static_flag), 32'(e_static));
      chk("static_level", 32'(static_level), 32'(e_slevel));
   endtask

   task automatic run(input logic p, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = p;
         @(posedge clk);
         cyc++;
         model_edge();
         #1;
         check_all();
      end
   endtask

   // Asynchronous reset in the middle of a clk, checked before the next edge.
   task automatic do_reset();
      #3 rst_n = 1'b0;
      model_clear();
      #1 check_all();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int h, l;
      model_clear();
      repeat (3) @(posedge clk);
      #1 check_all();
      rst_n = 1'b1;

      // Nominal 25% duty, 256-tick period.
      run(0, 20);
      repeat (5) begin run(1, 256); run(0, 768); end

      // Random high/low lengths.
      repeat (6) begin
         h = int'($urandom_range(8, 1000));
         l = int'($urandom_range(8, 1000));
         run(1, h); run(0, l);
      end

      // High time above 255 ticks saturates duty.
      repeat (2) begin run(1, 1200); run(0, 848); end

      // Static high, then a fresh measurement.
      run(1, 2000);
      run(0, 500); run(1, 300); run(0, 400); run(1, 100);

      // Reset mid-HIGH discards the partial measurement.
      run(0, 300); run(1, 100);
      do_reset();
      run(1, 100); run(0, 300); run(1, 200); run(0, 300); run(1, 50);

      // ena dropped mid-LOW for 50 clk.
      run(0, 150);
      ena = 1'b0;
      run(0, 50);
      ena = 1'b1;
      run(0, 200); run(1, 180); run(0, 400); run(1, 220); run(0, 300); run(1, 60);

      // One-clk glitch inside a low phase.
      run(0, 150); run(1, 1); run(0, 150);
      run(1, 200); run(0, 300); run(1, 10);

      // Static low with a random tail.
      run(0, 1800 + int'($urandom_range(0, 100)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
